// File: rtl/dff_bank_write_arbiter.sv
// rtl/dff_bank_write_arbiter.sv - round-robin arbiter and write sequencer for a falling-edge storage register
module dff_bank_write_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata,
  input  logic                  clr,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      q,
  output logic                  q_valid,
  output logic                  busy
);

  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t           state;
  logic [LW-1:0]    last;
  logic [LW-1:0]    gsel;
  logic [LW-1:0]    win;
  logic [WIDTH-1:0] wsel;

  // First requester after the last serviced one; later slots are overridden by nearer ones.
  function automatic logic [LW-1:0] pick(input logic [NREQ-1:0] r, input logic [LW-1:0] l);
    logic [LW-1:0] w;
    logic [LW-1:0] idx;
    w = l;
    for (int k = NREQ; k >= 1; k--) begin
      idx = LW'((int'(l) + k) % NREQ);
      if (r[idx]) w = idx;
    end
    return w;
  endfunction

  // Combinational winner for the current pointer and request vector
  always_comb begin
    win = pick(req, last);
  end

  // Write data of the granted requester
  always_comb begin
    wsel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gsel == LW'(i)) wsel = wdata[i*WIDTH +: WIDTH];
    end
  end

  // Arbitration FSM and storage register, all updating on the falling edge
  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      gnt     <= '0;
      ack     <= '0;
      q       <= '0;
      q_valid <= 1'b0;
      last    <= LW'(NREQ - 1);
      gsel    <= '0;
    end else begin
      // clr clears storage in every state; in GRANT it also blocks the commit below
      if (clr) begin
        q       <= '0;
        q_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (|req) begin
            gnt   <= NREQ'(1) << win;
            gsel  <= win;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (!req[gsel]) begin
            gnt   <= '0;
            state <= IDLE;
          end else if (!clr) begin
            q       <= wsel;
            q_valid <= 1'b1;
            ack     <= gnt;
            gnt     <= '0;
            last    <= gsel;
            state   <= ACK;
          end
        end
        ACK: begin
          ack <= '0;
          if (|req) begin
            gnt   <= NREQ'(1) << win;
            gsel  <= win;
            state <= GRANT;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          gnt   <= '0;
          ack   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_dff_bank_write_arbiter.sv
// tb/tb_dff_bank_write_arbiter.sv - self-checking bench for dff_bank_write_arbiter
module tb_dff_bank_write_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic                  clock;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] wdata;
  logic                  clr;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       ack;
  logic [WIDTH-1:0]      q;
  logic                  q_valid;
  logic                  busy;

  int errors = 0;
  int checks = 0;

  // reference model: phase 0 idle, 1 granted, 2 acknowledging
  int         m_phase;
  int         m_owner;
  int         m_last;
  logic [7:0] m_q;
  logic       m_qv;

  typedef struct {
    logic [3:0] req;
    logic       clr;
    logic [3:0] gnt;
    logic [3:0] ack;
    logic [7:0] q;
    logic       qv;
    logic       busy;
  } vec_t;

  vec_t tbl[26];

  dff_bank_write_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clock   (clock),
    .reset   (reset),
    .req     (req),
    .wdata   (wdata),
    .clr     (clr),
    .gnt     (gnt),
    .ack     (ack),
    .q       (q),
    .q_valid (q_valid),
    .busy    (busy)
  );

  initial begin
    clock = 1'b1;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int l);
    for (int k = 1; k <= NREQ; k++) begin
      if (r[(l + k) % NREQ]) return (l + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_owner = 0;
    m_last  = NREQ - 1;
    m_q     = '0;
    m_qv    = 1'b0;
  endtask

  task automatic model_edge(input logic [3:0] r, input logic c, input logic [31:0] w);
    if (c) begin
      m_q  = '0;
      m_qv = 1'b0;
    end
    if (m_phase == 1) begin
      if (!r[m_owner]) m_phase = 0;
      else if (!c) begin
        m_q     = w[m_owner*8 +: 8];
        m_qv    = 1'b1;
        m_last  = m_owner;
        m_phase = 2;
      end
    end else if (r != 0) begin
      m_owner = pick(r, m_last);
      m_phase = 1;
    end else begin
      m_phase = 0;
    end
  endtask

  task automatic check_model();
    logic [3:0] eg;
    logic [3:0] ea;
    eg = (m_phase == 1) ? 4'(1 << m_owner) : 4'b0;
    ea = (m_phase == 2) ? 4'(1 << m_last) : 4'b0;
    chk("model_gnt", 32'(gnt), 32'(eg));
    chk("model_ack", 32'(ack), 32'(ea));
    chk("model_q", 32'(q), 32'(m_q));
    chk("model_qv", 32'(q_valid), 32'(m_qv));
    chk("model_busy", 32'(busy), 32'(m_phase != 0));
    chk("invariant", 32'($onehot0(gnt) && $onehot0(ack) && !((|gnt) && (|ack))), 32'(1));
  endtask

  task automatic tick();
    model_edge(req, clr, wdata);
    @(negedge clock);
    #1;
    check_model();
  endtask

  initial begin
    tbl[0]  = '{4'b1111, 1'b0, 4'b0001, 4'b0000, 8'h00, 1'b0, 1'b1};
    tbl[1]  = '{4'b1111, 1'b0, 4'b0000, 4'b0001, 8'hC3, 1'b1, 1'b1};
    tbl[2]  = '{4'b1110, 1'b0, 4'b0010, 4'b0000, 8'hC3, 1'b1, 1'b1};
    tbl[3]  = '{4'b1110, 1'b0, 4'b0000, 4'b0010, 8'h5B, 1'b1, 1'b1};
    tbl[4]  = '{4'b1101, 1'b0, 4'b0100, 4'b0000, 8'h5B, 1'b1, 1'b1};
    tbl[5]  = '{4'b1101, 1'b0, 4'b0000, 4'b0100, 8'hA5, 1'b1, 1'b1};
    tbl[6]  = '{4'b1011, 1'b0, 4'b1000, 4'b0000, 8'hA5, 1'b1, 1'b1};
    tbl[7]  = '{4'b1011, 1'b0, 4'b0000, 4'b1000, 8'hD4, 1'b1, 1'b1};
    tbl[8]  = '{4'b0111, 1'b0, 4'b0001, 4'b0000, 8'hD4, 1'b1, 1'b1};
    tbl[9]  = '{4'b0111, 1'b0, 4'b0000, 4'b0001, 8'hC3, 1'b1, 1'b1};
    tbl[10] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 8'hC3, 1'b1, 1'b0};
    tbl[11] = '{4'b0010, 1'b0, 4'b0010, 4'b0000, 8'hC3, 1'b1, 1'b1};
    tbl[12] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 8'hC3, 1'b1, 1'b0};
    tbl[13] = '{4'b1010, 1'b0, 4'b0010, 4'b0000, 8'hC3, 1'b1, 1'b1};
    tbl[14] = '{4'b1010, 1'b0, 4'b0000, 4'b0010, 8'h5B, 1'b1, 1'b1};
    tbl[15] = '{4'b1000, 1'b0, 4'b1000, 4'b0000, 8'h5B, 1'b1, 1'b1};
    tbl[16] = '{4'b1000, 1'b0, 4'b0000, 4'b1000, 8'hD4, 1'b1, 1'b1};
    tbl[17] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 8'hD4, 1'b1, 1'b0};
    tbl[18] = '{4'b0100, 1'b0, 4'b0100, 4'b0000, 8'hD4, 1'b1, 1'b1};
    tbl[19] = '{4'b0100, 1'b0, 4'b0000, 4'b0100, 8'hA5, 1'b1, 1'b1};
    tbl[20] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 8'hA5, 1'b1, 1'b0};
    tbl[21] = '{4'b0001, 1'b0, 4'b0001, 4'b0000, 8'hA5, 1'b1, 1'b1};
    tbl[22] = '{4'b0001, 1'b1, 4'b0001, 4'b0000, 8'h00, 1'b0, 1'b1};
    tbl[23] = '{4'b0001, 1'b0, 4'b0000, 4'b0001, 8'hC3, 1'b1, 1'b1};
    tbl[24] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 8'hC3, 1'b1, 1'b0};
    tbl[25] = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 8'h00, 1'b0, 1'b0};

    reset = 1'b0;
    req   = 4'b1111;
    clr   = 1'b0;
    wdata = 32'hD4A55BC3;
    model_reset();
    repeat (2) @(negedge clock);
    #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_qv", 32'(q_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    reset = 1'b1;

    for (int i = 0; i < 26; i++) begin
      req = tbl[i].req;
      clr = tbl[i].clr;
      tick();
      chk($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
      chk($sformatf("vec%0d_ack", i), 32'(ack), 32'(tbl[i].ack));
      chk($sformatf("vec%0d_q", i), 32'(q), 32'(tbl[i].q));
      chk($sformatf("vec%0d_qv", i), 32'(q_valid), 32'(tbl[i].qv));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
    end
    clr = 1'b0;

    // asynchronous reset while requester 3 holds the grant
    req = 4'b1000;
    tick();
    chk("areset_pre_gnt", 32'(gnt), 32'h8);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk("areset_gnt", 32'(gnt), 32'h0);
    chk("areset_busy", 32'(busy), 32'h0);
    chk("areset_q", 32'(q), 32'h0);
    req = 4'b1001;
    #1;
    reset = 1'b1;
    tick();
    chk("areset_prio_gnt", 32'(gnt), 32'h1);
    req = 4'b0001;
    tick();
    chk("areset_ack", 32'(ack), 32'h1);
    chk("areset_q_after", 32'(q), 32'hC3);
    req = 4'b0000;
    tick();

    // randomized traffic against the reference model
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (m_phase == 2 && m_last == i) begin
          if ($urandom_range(9) != 0) req[i] = 1'b0;
        end else if (!req[i]) begin
          if ($urandom_range(2) == 0) begin
            req[i] = 1'b1;
            wdata[i*8 +: 8] = 8'($urandom);
          end
        end else if ($urandom_range(19) == 0) begin
          req[i] = 1'b0;
        end
      end
      clr = ($urandom_range(19) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dff_bank_write_arbiter.md
Name: dff_bank_write_arbiter

Overview:
- Round-robin arbiter and write sequencer for a shared WIDTH-bit storage register built from falling-edge D flip-flops.
- Up to NREQ requesters compete to load the register.
- The block grants one requester at a time, commits its data, acknowledges it, and exposes the stored value and a valid flag.
- All state updates on the falling edge of clock, matching the storage cells it drives.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, storage register width in bits.

Ports:
- clock  input  1  single clock; all state updates on negedge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- req  input  NREQ  per-requester write request; level, held until ack.
- wdata  input  NREQ*WIDTH  packed write data; requester i uses bits [i*WIDTH +: WIDTH]; held stable while req[i]=1.
- clr  input  1  synchronous clear of stored value.
- gnt  output  NREQ  one-hot grant; registered.
- ack  output  NREQ  one-hot write-done pulse, exactly one cycle.
- q  output  WIDTH  stored register value.
- q_valid  output  1  q holds committed data since last reset/clr.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Reset (reset=0, asynchronous, any time):
  - state=IDLE; gnt=0; ack=0; q=0; q_valid=0; busy=0.
  - Round-robin pointer last=NREQ-1, so req[0] has top priority first.
  - Reset mid-transaction aborts it with no write and no ack.
- FSM states: IDLE, GRANT, ACK; busy=1 in GRANT and ACK.
- Arbitration function: first i with req[i]=1, searching last+1, last+2, ... mod NREQ.
- IDLE, negedge:
  - If any req: gnt <= onehot(winner), state -> GRANT.
  - Else stay in IDLE.
- GRANT (gnt[g]=1), negedge:
  - req[g]=1 and clr=0: q <= wdata[g]; q_valid <= 1; ack[g] <= 1; gnt <= 0; last <= g; state -> ACK.
  - req[g]=1 and clr=1: clr wins. q <= 0; q_valid <= 0; no ack; gnt[g] held; stay in GRANT (retry next edge).
  - req[g]=0 (requester withdrew): abort. gnt <= 0; last unchanged; no write; state -> IDLE.
- ACK (one cycle), negedge:
  - ack <= 0.
  - If any req: arbitrate with updated last; gnt <= onehot(winner), state -> GRANT.
  - Else state -> IDLE.
- Requester rules:
  - Must drop req during its ack cycle.
  - req still high at the ACK-exit edge counts as a new request at lowest priority.
- Latency:
  - req sampled at edge k in IDLE -> gnt after k.
  - q, q_valid, ack after k+1; ack low after k+2.
  - Back-to-back service: one write every 2 cycles.
- clr outside GRANT: q <= 0, q_valid <= 0 at that edge; FSM unaffected.
- Output invariants:
  - gnt and ack never both nonzero.
  - At most one bit of each is set.
  - q changes only on a commit, clr, or reset.

Test Plan:
- Reset: hold reset=0 with req=4'b1111 -> gnt=0, ack=0, q=0, q_valid=0; release -> gnt=0001 after first negedge.
- Single write: req[2]=1, wdata[2]=8'hA5 -> gnt=0100 next negedge, then q=A5, q_valid=1, ack=0100 for exactly one cycle.
- Round-robin fairness: req=1111 held, each requester drops req in its ack cycle and re-asserts next cycle -> grant order 0,1,2,3,0,...; q sequence matches each requester's wdata; one write per 2 cycles.
- Withdraw: req[1]=1 until gnt=0010, then drop -> no ack, q unchanged, FSM to IDLE; later req[1]/req[3] both high -> req[1] granted (pointer unchanged).
- clr during GRANT: q=3C, q_valid=1, grant to requester 0 with clr=1 on that edge -> q=0, q_valid=0, no ack, gnt held; next edge with clr=0 -> q=wdata[0], ack[0].
- Async reset mid-GRANT: drop reset between edges while gnt=1000 -> all outputs zero immediately; after release req[0] wins before req[3].
